// File: rtl/i2c_rtc_responder_if.sv
// Pin-level I2C bundle between a bus controller and the RTC responder.
// sda_i is the resolved line level; sda_oe = 1 pulls SDA low.
interface i2c_rtc_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_rtc_responder.sv
// I2C target exposing an MCP7940N-style RTC register map (r0..r6 datetime, r7 control)
// with an auto-incrementing pointer and a host-side 56-bit BCD load port.
module i2c_rtc_responder #(
  parameter logic [6:0] c_addr = 7'h6F
) (
  input  logic                      clk,
  input  logic                      reset,
  i2c_rtc_responder_if.slave        bus,
  input  logic                      load,
  input  logic [55:0]               load_datetime,
  output logic [55:0]               datetime,
  output logic                      wr_strobe,
  output logic [2:0]                wr_addr
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAckAddr,
    StPtr,
    StAckPtr,
    StWdata,
    StAckWdata,
    StRdata,
    StRack,
    StWaitStop
  } state_e;

  // Pin synchronizers, history flops and registered bus events
  logic r_scl_meta, r_scl_sync, r_scl_hist;
  logic r_sda_meta, r_sda_sync, r_sda_hist;
  logic r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_bit;

  state_e     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_ack_drv;
  logic [2:0] r_ptr;
  logic       r_sda_oe;
  logic       r_wr_strobe;
  logic [2:0] r_wr_addr;
  logic [7:0] r_regs [8];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic [2:0] w_ptr_inc;
  logic       w_commit;

  assign w_scl_rise  = r_scl_sync & ~r_scl_hist;
  assign w_scl_fall  = ~r_scl_sync & r_scl_hist;
  assign w_start     = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
  assign w_stop      = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;
  assign w_byte      = {r_shift[6:0], r_sda_bit};
  assign w_byte_done = (r_bit_cnt == 4'd7);
  assign w_ptr_inc   = r_ptr + 3'd1;
  assign w_commit    = (r_state == StWdata) & r_scl_rise & w_byte_done & ~r_start & ~r_stop;

  // SDA flops reset low so the only artefact of reset on an idle bus is a harmless STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b0;
      r_sda_sync <= 1'b0;
      r_sda_hist <= 1'b0;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_sda_bit  <= 1'b1;
    end else begin
      r_scl_meta <= bus.scl_i;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= bus.sda_i;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
      r_scl_rise <= w_scl_rise;
      r_scl_fall <= w_scl_fall;
      r_start    <= w_start;
      r_stop     <= w_stop;
      r_sda_bit  <= r_sda_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_ptr       <= 3'd0;
      r_sda_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 3'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (r_start) begin
        r_state   <= StAddr;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_ack_drv <= 1'b0;
      end else if (r_stop) begin
        r_state   <= StIdle;
        r_sda_oe  <= 1'b0;
        r_ack_drv <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle, StWaitStop: begin
          end
          StAddr: begin
            if (r_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= w_byte_done ? 4'd0 : r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                if (w_byte[7:1] == c_addr) begin
                  r_rw    <= w_byte[0];
                  r_state <= StAckAddr;
                end else begin
                  r_state <= StWaitStop;
                end
              end
            end
          end
          StPtr: begin
            if (r_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= w_byte_done ? 4'd0 : r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                r_ptr   <= w_byte[2:0];
                r_state <= StAckPtr;
              end
            end
          end
          StWdata: begin
            if (r_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= w_byte_done ? 4'd0 : r_bit_cnt + 4'd1;
              if (w_byte_done) begin
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_ptr;
                r_ptr       <= w_ptr_inc;
                r_state     <= StAckWdata;
              end
            end
          end
          // First fall after the 8th bit starts the ACK, the next one ends it.
          StAckAddr, StAckPtr, StAckWdata: begin
            if (r_scl_fall) begin
              if (!r_ack_drv) begin
                r_ack_drv <= 1'b1;
                r_sda_oe  <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                if ((r_state == StAckAddr) && r_rw) begin
                  r_sda_oe  <= ~r_regs[r_ptr][7];
                  r_shift   <= {r_regs[r_ptr][6:0], 1'b0};
                  r_bit_cnt <= 4'd1;
                  r_state   <= StRdata;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= 4'd0;
                  r_state   <= (r_state == StAckAddr) ? StPtr : StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (r_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= StRack;
              end else begin
                r_sda_oe  <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          StRack: begin
            if (r_scl_rise) begin
              r_ptr <= w_ptr_inc;
              if (!r_sda_bit) begin
                r_shift   <= r_regs[w_ptr_inc];
                r_bit_cnt <= 4'd0;
                r_state   <= StRdata;
              end else begin
                r_state <= StWaitStop;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Host load is applied after the I2C commit so it wins on r0..r6.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_commit) r_regs[r_ptr] <= w_byte;
      if (load) begin
        for (int i = 0; i < 7; i++) r_regs[i] <= load_datetime[8*i +: 8];
      end
    end
  end

  assign bus.sda_oe = r_sda_oe;
  assign datetime   = {r_regs[6], r_regs[5], r_regs[4], r_regs[3],
                       r_regs[2], r_regs[1], r_regs[0]};
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;

endmodule
